// File: rtl/mac_array_ctrl.sv
// Controller for a 4x4 MAC array: owns the weight registers, feeds input vectors
// into the fixed-latency array and queues its results in a fall-through FIFO.
module mac_array_ctrl #(
    parameter int LAT   = 4,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   num_vec,
    output logic         busy,
    output logic         done,
    input  logic         w_we,
    input  logic [3:0]   w_addr,
    input  logic [7:0]   w_data,
    output logic [127:0] weights,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    output logic [31:0]  arr_in,
    input  logic [31:0]  arr_res,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic [1:0]   dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     num_vec_q, num_vec_d;
    logic [7:0]     accepted_q, accepted_d;
    logic           zero_done_q, zero_done_d;
    logic [LAT-1:0] tag_q, tag_d;
    logic [31:0]    arr_in_q, arr_in_d;
    logic [127:0]   weights_q, weights_d;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  fifo_count_q;
    logic [5:0]     inflight, occupancy;
    logic           hs, push, pop, fifo_empty, drain_done;

    // Handshakes (in_* and out_*): a transfer happens on a rising edge where valid
    // and ready are both high; ready never depends on valid, and the sender holds
    // data stable while valid is high and ready is low.
    assign inflight   = 6'($countones(tag_q));
    assign occupancy  = inflight + 6'(fifo_count_q);
    assign fifo_empty = (fifo_count_q == '0);
    assign in_ready   = (state_q == RUN) && (accepted_q < num_vec_q) && (occupancy < 6'(DEPTH));
    assign hs         = in_valid && in_ready;
    assign push       = tag_q[LAT-1];
    assign pop        = !fifo_empty && out_ready;
    assign drain_done = (state_q == DRAIN) && (inflight == 6'd0) && fifo_empty;

    assign busy      = (state_q != IDLE);
    assign done      = !reset && (zero_done_q || drain_done);
    assign weights   = weights_q;
    assign arr_in    = arr_in_q;
    assign out_valid = !fifo_empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        num_vec_d   = num_vec_q;
        accepted_d  = accepted_q;
        zero_done_d = 1'b0;
        weights_d   = weights_q;
        case (state_q)
            IDLE: begin
                if (w_we) weights_d[{w_addr, 3'b000} +: 8] = w_data;
                if (start) begin
                    num_vec_d  = num_vec;
                    accepted_d = '0;
                    if (num_vec == 8'd0) zero_done_d = 1'b1;
                    else                 state_d     = RUN;
                end
            end
            RUN:     if (accepted_q == num_vec_q) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (hs) accepted_d = accepted_q + 8'd1;
    end

    // Low LAT bits of {tag, hs}: a one-stage shift that also works for LAT=1.
    always_comb begin
        tag_d    = LAT'({tag_q, hs});
        arr_in_d = hs ? in_data : 32'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            num_vec_q   <= '0;
            accepted_q  <= '0;
            zero_done_q <= 1'b0;
            tag_q       <= '0;
            arr_in_q    <= '0;
            weights_q   <= '0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            accepted_q  <= accepted_d;
            zero_done_q <= zero_done_d;
            tag_q       <= tag_d;
            arr_in_q    <= arr_in_d;
            weights_q   <= weights_d;
        end
    end

    // Result FIFO; entries are cleared on reset so out_data reads 0 afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= arr_res;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 1'b1;
                2'b01:   fifo_count_q <= fifo_count_q - 1'b1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl: directed jobs, a delay-line array model and an
// in-order result scoreboard checked by an independent output monitor.
module tb_mac_array_ctrl;
    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   num_vec = '0;
    logic         busy, done;
    logic         w_we = 1'b0;
    logic [3:0]   w_addr = '0;
    logic [7:0]   w_data = '0;
    logic [127:0] weights;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic [31:0]  arr_in;
    logic [31:0]  arr_res;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic [1:0]   dbg_state;

    mac_array_ctrl #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .start(start), .num_vec(num_vec),
        .busy(busy), .done(done), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .weights(weights), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .arr_in(arr_in), .arr_res(arr_res), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- array model ----------------
    function automatic logic [31:0] model(input logic [31:0] d);
        return d + 32'h0101_0101;
    endfunction

    logic [31:0] pipe_q [LAT-1];
    always @(posedge clock) begin
        pipe_q[0] <= arr_in;
        for (int i = 1; i < LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign arr_res = model(pipe_q[LAT-2]);

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rx_cnt = 0;
    logic        stall_seen = 1'b0;
    logic [31:0] stall_data = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (done) done_cnt++;
            if (dut.tag_q[LAT-1] && (dut.fifo_count_q == DEPTH)) begin
                errors++;
                $display("FAIL fifo_overflow push into full fifo at %0t", $time);
            end
            if (stall_seen && out_valid) check("out_hold", out_data, stall_data);
            if (out_valid && out_ready) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=none", out_data);
                end else begin
                    check("result", out_data, exp_q.pop_front());
                end
            end
            stall_seen = out_valid && !out_ready;
            stall_data = out_data;
        end else begin
            stall_seen = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_job(input logic [7:0] n);
        start = 1'b1;
        num_vec = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        check("send_timeout", {127'd0, in_ready}, 128'd1);
        if (in_ready) exp_q.push_back(model(d));
        tick();
        in_valid = 1'b0;
        in_data = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        check(name, {127'd0, busy}, 128'd0);
    endtask

    function automatic logic [31:0] vec(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // ---------------- directed sequence ----------------
    logic [127:0] w_exp;
    int d0, r0;

    initial begin
        // reset with start, w_we and in_valid all asserted: reset wins
        start = 1'b1; num_vec = 8'd5; w_we = 1'b1; w_addr = 4'd3; w_data = 8'h77;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        repeat (3) tick();
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd0);
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_arr_in", {96'd0, arr_in}, 128'd0);
        check("rst_out_data", {96'd0, out_data}, 128'd0);
        check("rst_weights", weights, 128'd0);
        start = 1'b0; w_we = 1'b0; in_valid = 1'b0; in_data = '0;
        reset = 1'b0;
        tick();

        // weight load in IDLE
        for (int k = 0; k < 16; k++) begin
            w_we = 1'b1; w_addr = 4'(k); w_data = 8'(k + 1);
            w_exp[8*k +: 8] = 8'(k + 1);
            tick();
        end
        w_we = 1'b0;
        check("w_low", {120'd0, weights[7:0]}, 128'd1);
        check("w_high", {120'd0, weights[127:120]}, 128'd16);
        check("w_all", weights, w_exp);

        // zero-length job
        d0 = done_cnt;
        start_job(8'd0);
        check("zero_done", {127'd0, done}, 128'd1);
        check("zero_busy", {127'd0, busy}, 128'd0);
        check("zero_in_ready", {127'd0, in_ready}, 128'd0);
        tick();
        check("zero_done_off", {127'd0, done}, 128'd0);
        check("zero_in_ready2", {127'd0, in_ready}, 128'd0);

        // single vector, timing relative to the handshake cycle
        out_ready = 1'b1;
        start_job(8'd1);
        check("sv_in_ready", {127'd0, in_ready}, 128'd1);
        in_valid = 1'b1; in_data = 32'h0403_0201;
        exp_q.push_back(32'h0504_0302);
        tick();
        in_valid = 1'b0; in_data = '0;
        check("sv_arr_in", {96'd0, arr_in}, 128'h0403_0201);
        w_we = 1'b1; w_addr = 4'd0; w_data = 8'hFF;
        tick();
        w_we = 1'b0;
        check("sv_arr_in_clr", {96'd0, arr_in}, 128'd0);
        check("sv_ov_early", {127'd0, out_valid}, 128'd0);
        tick();
        tick();
        check("sv_ov_early2", {127'd0, out_valid}, 128'd0);
        tick();
        check("sv_ov", {127'd0, out_valid}, 128'd1);
        check("sv_data", {96'd0, out_data}, 128'h0504_0302);
        tick();
        check("sv_done", {127'd0, done}, 128'd1);
        check("sv_ov_gone", {127'd0, out_valid}, 128'd0);
        tick();
        check("sv_done_off", {127'd0, done}, 128'd0);
        check("sv_idle", {127'd0, busy}, 128'd0);
        check("sv_w_kept", weights, w_exp);

        // backpressure: 10 vectors, FIFO credit limits acceptance to 4
        d0 = done_cnt; r0 = rx_cnt;
        out_ready = 1'b0;
        start_job(8'd10);
        for (int i = 0; i < 4; i++) send(vec(i));
        check("bp_in_ready_low", {127'd0, in_ready}, 128'd0);
        repeat (LAT + 2) tick();
        check("bp_in_ready_low2", {127'd0, in_ready}, 128'd0);
        check("bp_ov", {127'd0, out_valid}, 128'd1);
        fork
            begin
                for (int i = 4; i < 10; i++) send(vec(i));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    out_ready = (c % 3 != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_idle("bp_idle_timeout");
        tick();
        check("bp_rx", 128'(rx_cnt - r0), 128'd10);
        check("bp_done_once", 128'(done_cnt - d0), 128'd1);
        check("bp_q_empty", 128'(exp_q.size()), 128'd0);

        // reset in DRAIN with two results queued
        out_ready = 1'b0;
        start_job(8'd2);
        send(vec(20));
        send(vec(21));
        repeat (LAT + 3) tick();
        check("rd_state_drain", {126'd0, dbg_state}, 128'd2);
        check("rd_ov", {127'd0, out_valid}, 128'd1);
        d0 = done_cnt;
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("rd_ov_cleared", {127'd0, out_valid}, 128'd0);
        check("rd_busy", {127'd0, busy}, 128'd0);
        check("rd_done", {127'd0, done}, 128'd0);
        tick();
        check("rd_no_done", 128'(done_cnt - d0), 128'd0);
        r0 = rx_cnt;
        out_ready = 1'b1;
        start_job(8'd2);
        send(vec(30));
        send(vec(31));
        wait_idle("rd_clean_timeout");
        tick();
        check("rd_clean_rx", 128'(rx_cnt - r0), 128'd2);
        check("rd_clean_done", 128'(done_cnt - d0), 128'd1);
        check("rd_clean_q", 128'(exp_q.size()), 128'd0);

        // start while busy, pushes coinciding with pops near full
        d0 = done_cnt; r0 = rx_cnt;
        out_ready = 1'b0;
        start_job(8'd6);
        for (int i = 0; i < 4; i++) send(vec(40 + i));
        repeat (LAT + 2) tick();
        check("sb_in_ready_low", {127'd0, in_ready}, 128'd0);
        start_job(8'd1);
        check("sb_still_run", {126'd0, dbg_state}, 128'd1);
        fork
            begin
                send(vec(44));
                send(vec(45));
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    out_ready = (c % 2 == 1);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_idle("sb_idle_timeout");
        tick();
        check("sb_rx", 128'(rx_cnt - r0), 128'd6);
        check("sb_done_once", 128'(done_cnt - d0), 128'd1);
        check("sb_q_empty", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_array_ctrl.md
MAC_ARRAY_CTRL -- requirements
Module: mac_array_ctrl

Interface
REQ-001 The block SHALL have parameter LAT, default 4, meaning array latency in cycles from arr_in update to the matching arr_res; legal range 1..15.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning result FIFO entries; power of two, 2..16.
REQ-003 The block SHALL use one clock and a synchronous active-high reset; clock and reset SHALL be the first two ports, named clock and reset.
REQ-004 The block SHALL have port clock, in, 1, rising-edge clock.
REQ-005 The block SHALL have port reset, in, 1, synchronous active-high reset.
REQ-006 The block SHALL have port start, in, 1, job start pulse.
REQ-007 The block SHALL have port num_vec, in, 8, vectors in the job, sampled with start.
REQ-008 The block SHALL have port busy, out, 1, high whenever state is not IDLE.
REQ-009 The block SHALL have port done, out, 1, one-cycle job-complete pulse.
REQ-010 The block SHALL have ports w_we (in, 1), w_addr (in, 4) and w_data (in, 8), forming the weight write port.
REQ-011 The block SHALL have port weights, out, 128, weight bus to the array; entry k at bits [8k+7:8k], k = 4*(row-1)+(col-1).
REQ-012 The block SHALL have ports in_valid (in, 1), in_ready (out, 1) and in_data (in, 32), forming the input vector handshake; i1 at [7:0] through i4 at [31:24].
REQ-013 The block SHALL have port arr_in, out, 32, registered input vector to the array.
REQ-014 The block SHALL have port arr_res, in, 32, activated array results {r16, r12, r8, r4}.
REQ-015 The block SHALL have ports out_valid (out, 1), out_ready (in, 1) and out_data (out, 32), forming the result handshake.

Function
REQ-016 The block SHALL implement the states IDLE, RUN and DRAIN.
REQ-017 In IDLE, start=1 SHALL latch num_vec and zero the accepted count.
  - num_vec=0: done pulses next cycle; state stays IDLE.
  - Otherwise: go to RUN.
REQ-018 When busy=1, start SHALL be ignored.
REQ-019 A weight write SHALL occur when w_we=1 in IDLE: weights[w_addr] <= w_data.
  - In RUN or DRAIN, w_we SHALL be ignored, so weights stay stable during a job.
REQ-020 in_ready SHALL be high only when all three hold:
  - state=RUN;
  - accepted < num_vec;
  - fifo_count + inflight < DEPTH, where inflight = number of set tag bits.
  - in_ready SHALL be combinational from registered state only, with no dependence on in_valid.
REQ-021 On an input handshake (in_valid and in_ready both high):
  - arr_in <= in_data;
  - tag[0] <= 1;
  - accepted increments.
REQ-022 In any cycle without an input handshake, arr_in SHALL be set to 0 and tag[0] to 0.
REQ-023 The tag shift register SHALL advance by one stage every cycle.
  - When tag[LAT-1]=1, arr_res SHALL be pushed into the FIFO on that edge.
  - Net effect: out_valid rises LAT+1 cycles after the handshake cycle when the FIFO is empty.
REQ-024 The FIFO SHALL be first-word-fall-through.
  - out_valid = FIFO non-empty; out_data = head entry.
  - The head is popped when out_valid and out_ready are both high.
  - out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 A simultaneous push and pop SHALL leave fifo_count unchanged.
  - A pop's freed credit becomes visible to in_ready in the next cycle.
REQ-026 A push into a full FIFO SHALL be impossible by REQ-020; the bench SHALL assert on it.
REQ-027 In RUN, accepted = num_vec SHALL move the state to DRAIN.
REQ-028 In DRAIN, inflight=0 and an empty FIFO SHALL cause a done pulse for one cycle and a transition to IDLE.
REQ-029 Results SHALL leave in input order, exactly num_vec results per job, with no drop or duplication under arbitrary out_ready stalls.

Reset
REQ-030 On reset the block SHALL set:
  - state to IDLE;
  - busy, done, in_ready and out_valid to 0;
  - arr_in, out_data and weights to 0;
  - all tags, the FIFO pointers, fifo_count and accepted to 0.
REQ-031 Reset asserted mid-job SHALL abort the job: in-flight and queued results are discarded and done is not pulsed.
REQ-032 Reset SHALL take priority over start, w_we and any handshake in the same cycle.

Verification
REQ-033 Weight load: write addr 0..15 with values 1..16 in IDLE -> weights[7:0]=1 and weights[127:120]=16; a w_we issued during RUN -> weights unchanged.
REQ-034 Single vector, LAT=4, out_ready=1: handshake in cycle 10 with in_data=0x04030201 -> arr_in=0x04030201 in cycle 11 and 0 in cycle 12; arr_res captured, out_valid=1 in cycle 15; done=1 in cycle 16.
REQ-035 Backpressure: num_vec=10, out_ready=0 -> in_ready drops after 4 handshakes; after out_ready=1, all 10 results arrive in order and done pulses once.
REQ-036 num_vec=0 -> done=1 one cycle after start, busy stays 0, in_ready stays 0.
REQ-037 Reset in DRAIN with 2 results queued -> next cycle out_valid=0 and busy=0, with no done pulse; a following start runs a clean job.
REQ-038 start while busy, together with simultaneous push and pop at a full FIFO -> accepted count, the FIFO and in-order delivery are unaffected.
